// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Brief    : Multi-cycle RV32M unsigned MUL/MULHU/DIVU/REMU sequencer that
//             borrows the shared add/subtract ALU, one ALU op per cycle
//             (shift-add multiply, restoring divide).
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_seq #(
   parameter int XLEN = 32,
   parameter int ITER = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [XLEN-1:0] alu_op1,
   output logic [XLEN-1:0] alu_op2,
   output logic            alu_ctrl,
   input  logic [XLEN-1:0] alu_out
);

   localparam int             CW       = $clog2(ITER);
   localparam logic [CW-1:0]  CNT_LAST = CW'(ITER - 1);

   localparam logic [1:0] OP_MUL   = 2'b00;
   localparam logic [1:0] OP_MULHU = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_REMU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_CALC = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      op_q, op_d;
   // hi_q/lo_q hold HI/LO for multiply and R/Q for divide; m_q is M or D.
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] m_q, m_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] result_q, result_d;

   logic            is_div;
   logic            last_iter;
   logic [XLEN-1:0] r_shift;
   logic            borrow;
   logic            carry;

   assign is_div    = op_q[1];
   assign last_iter = (cnt_q == CNT_LAST);
   assign r_shift   = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
   assign borrow    = (r_shift < m_q);
   assign carry     = (alu_out < hi_q);

   assign busy   = (state_q != ST_IDLE);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

   // Next-state logic: accept in IDLE, run ITER iterations, one DONE cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start)     state_d = ST_CALC;
         ST_CALC: if (last_iter) state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // Datapath: operand latch, one shift-add or restoring-divide step per cycle,
   // and ALU operand/control drive (zero whenever not iterating).
   always_comb begin
      op_d     = op_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      m_d      = m_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      alu_op1  = '0;
      alu_op2  = '0;
      alu_ctrl = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d  = op;
               hi_d  = '0;
               lo_d  = a;
               m_d   = b;
               cnt_d = '0;
            end
         end
         ST_CALC: begin
            if (!is_div) begin
               alu_op1  = hi_q;
               alu_op2  = m_q;
               alu_ctrl = 1'b0;
               if (lo_q[0]) begin
                  // carry out of HI+M becomes the new HI MSB after the shift
                  hi_d = {carry, alu_out[XLEN-1:1]};
                  lo_d = {alu_out[0], lo_q[XLEN-1:1]};
               end else begin
                  hi_d = {1'b0, hi_q[XLEN-1:1]};
                  lo_d = {hi_q[0], lo_q[XLEN-1:1]};
               end
            end else begin
               alu_op1  = r_shift;
               alu_op2  = m_q;
               alu_ctrl = 1'b1;
               // R[31] is the lost 33rd bit of the shifted remainder: the
               // true value exceeds D, and the wrapped subtract is exact.
               if (hi_q[XLEN-1] || !borrow) begin
                  hi_d = alu_out;
                  lo_d = {lo_q[XLEN-2:0], 1'b1};
               end else begin
                  hi_d = r_shift;
                  lo_d = {lo_q[XLEN-2:0], 1'b0};
               end
            end
            cnt_d = cnt_q + CW'(1);
            if (last_iter) begin
               unique case (op_q)
                  OP_MUL:   result_d = lo_d;
                  OP_MULHU: result_d = hi_d;
                  OP_DIVU:  result_d = lo_d;
                  OP_REMU:  result_d = hi_d;
                  default:  result_d = lo_d;
               endcase
            end
         end
         default: ;
      endcase
   end

   // State and datapath registers with asynchronous active-low clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         m_q      <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         m_q      <= m_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Brief    : Directed self-checking bench for muldiv_seq with an attached
//             add/subtract ALU model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_seq;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] alu_op1;
   logic [31:0] alu_op2;
   logic        alu_ctrl;
   logic [31:0] alu_out;

   int checks = 0;
   int errors = 0;

   muldiv_seq #(.XLEN(32), .ITER(32)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .op       (op),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .result   (result),
      .alu_op1  (alu_op1),
      .alu_op2  (alu_op2),
      .alu_ctrl (alu_ctrl),
      .alu_out  (alu_out)
   );

   // Shared execute-stage ALU: add or subtract op1 - op2.
   assign alu_out = alu_ctrl ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Issue one operation, optionally pulse start again at sample index inj,
   // and check latency, done count, result, ALU control and result hold.
   task automatic run_op(input string tag, input logic [1:0] o,
                         input logic [31:0] aa, input logic [31:0] bb,
                         input logic [31:0] exp, input logic exp_ctrl,
                         input int inj);
      int          cycles;
      int          dones;
      int          ctrl_bad;
      logic [31:0] got;
      cycles   = 0;
      dones    = 0;
      ctrl_bad = 0;
      got      = '0;
      @(negedge clk);
      op = o; a = aa; b = bb; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = ~o;
      a     = $urandom;
      b     = $urandom;
      while (busy && cycles < 100) begin
         start = (cycles == inj);
         if (done) begin
            dones++;
            got = result;
         end else if (alu_ctrl !== exp_ctrl) begin
            ctrl_bad++;
         end
         @(posedge clk);
         #1;
         cycles++;
      end
      start = 1'b0;
      chk({tag, " busy_cycles"}, 32'(cycles), 32'd33);
      chk({tag, " done_pulses"}, 32'(dones), 32'd1);
      chk({tag, " result"}, got, exp);
      chk({tag, " alu_ctrl_bad"}, 32'(ctrl_bad), 32'd0);
      @(posedge clk);
      #1;
      chk({tag, " idle_after"}, {31'd0, busy}, 32'd0);
      chk({tag, " result_held"}, result, exp);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      op    = 2'b00;
      a     = '0;
      b     = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst result", result, 32'd0);
      chk("rst alu_op1", alu_op1, 32'd0);
      chk("rst alu_op2", alu_op2, 32'd0);
      chk("rst alu_ctrl", {31'd0, alu_ctrl}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul_7x6",     2'b00, 32'd7,         32'd6,         32'd42,        1'b0, -1);
      run_op("mul_ffxff",   2'b00, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000001,  1'b0, -1);
      run_op("mulhu_ffxff", 2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  1'b0, -1);
      run_op("divu_100_7",  2'b10, 32'd100,       32'd7,         32'd14,        1'b1, -1);
      run_op("remu_100_7",  2'b11, 32'd100,       32'd7,         32'd2,         1'b1, -1);
      run_op("divu_r31",    2'b10, 32'hFFFFFFFF,  32'h80000001,  32'h00000001,  1'b1, -1);
      run_op("remu_r31",    2'b11, 32'hFFFFFFFF,  32'h80000001,  32'h7FFFFFFE,  1'b1, -1);
      run_op("divu_by0",    2'b10, 32'd5,         32'd0,         32'hFFFFFFFF,  1'b1, -1);
      run_op("remu_by0",    2'b11, 32'd5,         32'd0,         32'd5,         1'b1, -1);
      // start pulses while busy (mid-CALC, then in the DONE cycle) are ignored
      run_op("ign_calc",    2'b10, 32'd100,       32'd7,         32'd14,        1'b1, 5);
      run_op("ign_done",    2'b00, 32'd7,         32'd6,         32'd42,        1'b0, 32);

      // asynchronous reset ten cycles into a DIVU
      @(negedge clk);
      op = 2'b10; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      chk("pre_abort busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort done", {31'd0, done}, 32'd0);
      chk("abort result", result, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("mul_3x5",     2'b00, 32'd3,         32'd5,         32'd15,        1'b0, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
